// File: rtl/s_p_frame_buffer.sv
// Serial-to-parallel ping-pong frame buffer: collects 16 complex samples per
// frame in one bank while the other bank drains as four 4-lane beats.
module s_p_frame_buffer #(
    parameter int DW      = 34,
    parameter bit BIT_REV = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sop,
    input  logic [DW-1:0]   data_in,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [4*DW-1:0] data_out
);

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    logic [DW-1:0] mem [2][16];
    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [3:0]    wr_idx;
    logic [1:0]    beat;
    logic [3:0]    wr_slot;
    logic          wr_accept;
    logic          rd_accept;

    // Handshake outputs depend on registers only, never on in_valid/out_ready.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid & (beat == 2'd3);

    assign wr_accept = in_valid & in_ready;
    assign rd_accept = out_valid & out_ready;

    // A frame start always lands in slot 0, which bit-reversal leaves at 0.
    assign wr_slot = in_sop ? 4'd0 : (BIT_REV ? bitrev4(wr_idx) : wr_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= 4'd0;
            beat    <= 2'd0;
            full    <= 2'b00;
            // NOTE: the sample storage is cleared on reset so data_out reads as zero afterwards;
            // a plain RAM without reset would be cheaper when that is not needed.
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 16; s++) begin
                    mem[b][s] <= '0;
                end
            end
        end else begin
            // NOTE: all state here uses <= so every branch reads pre-edge values.
            if (wr_accept) begin
                mem[wr_bank][wr_slot] <= data_in;
                if (in_sop) begin
                    wr_idx <= 4'd1;
                end else if (wr_idx == 4'd15) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= 4'd0;
                end else begin
                    wr_idx <= wr_idx + 4'd1;
                end
            end
            // Write completion and read completion always touch different banks.
            if (rd_accept) begin
                if (beat == 2'd3) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    beat          <= 2'd0;
                end else begin
                    beat <= beat + 2'd1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves data_out unassigned (no latch).
        data_out = '0;
        for (int l = 0; l < 4; l++) begin
            data_out[l*DW +: DW] = mem[rd_bank][{beat, 2'(l)}];
        end
    end

endmodule

// File: tb/tb_s_p_frame_buffer.sv
// Bench for s_p_frame_buffer: natural and bit-reversed instances share one
// stimulus stream and are checked against a frame-level queue model.
module tb_s_p_frame_buffer;

    localparam int DW = 34;

    typedef logic [16*DW-1:0] frame_t;
    typedef logic [4*DW-1:0]  beat_t;

    typedef struct {
        logic [DW-1:0] din;
        logic          sop;
        logic          exp_in_ready;
    } in_vec_t;

    typedef struct {
        logic [15:0] nat;   // lane l expected value in nibble l
        logic [15:0] rev;
        logic        last;
    } beat_vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          in_ready0, in_ready1;
    logic          out_valid0, out_valid1;
    logic          out_last0, out_last1;
    beat_t         data_out0, data_out1;

    always #5 clk = ~clk;

    s_p_frame_buffer #(.DW(DW), .BIT_REV(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .data_in(data_in), .in_ready(in_ready0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .data_out(data_out0)
    );

    s_p_frame_buffer #(.DW(DW), .BIT_REV(1'b1)) dut_br (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .data_in(data_in), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .data_out(data_out1)
    );

    // Reference model: complete frames waiting/draining, plus the frame being collected.
    frame_t        frames_q[$];
    logic [DW-1:0] part [16];
    int            part_n;
    int            m_beat;

    int    checks;
    int    failures;
    int    dut_fires;
    int    dut_lasts;
    string cur_tag;

    in_vec_t   in_tbl   [16];
    beat_vec_t beat_tbl [4];

    task automatic check(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", cur_tag, name, act, exp);
        end
    endtask

    function automatic int bitrev4(input int v);
        return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
    endfunction

    // Slot s holds sample s (natural) or sample bitrev4(s) (reversed).
    function automatic beat_t exp_beat(input frame_t f, input int k, input bit rev);
        beat_t r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            int n;
            n = rev ? bitrev4(4*k + l) : 4*k + l;
            r[l*DW +: DW] = f[n*DW +: DW];
        end
        return r;
    endfunction

    function automatic beat_t widen(input logic [15:0] nib);
        beat_t r;
        r = '0;
        for (int l = 0; l < 4; l++) r[l*DW +: DW] = DW'(nib[4*l +: 4]);
        return r;
    endfunction

    task automatic model_clear();
        frames_q.delete();
        part_n = 0;
        m_beat = 0;
    endtask

    task automatic check_outputs();
        logic exp_rdy, exp_v, exp_last;
        exp_rdy  = frames_q.size() < 2;
        exp_v    = frames_q.size() > 0;
        exp_last = exp_v && (m_beat == 3);
        check("in_ready", beat_t'(in_ready0), beat_t'(exp_rdy));
        check("in_ready_br", beat_t'(in_ready1), beat_t'(exp_rdy));
        check("out_valid", beat_t'(out_valid0), beat_t'(exp_v));
        check("out_valid_br", beat_t'(out_valid1), beat_t'(exp_v));
        check("out_last", beat_t'(out_last0), beat_t'(exp_last));
        check("out_last_br", beat_t'(out_last1), beat_t'(exp_last));
        if (exp_v) begin
            check("data_out", data_out0, exp_beat(frames_q[0], m_beat, 1'b0));
            check("data_out_br", data_out1, exp_beat(frames_q[0], m_beat, 1'b1));
        end
    endtask

    // One clock: drive at negedge, advance the model, check 1 time unit after posedge.
    task automatic cycle(input logic v, input logic sop, input logic [DW-1:0] d,
                         input logic ordy, output logic acc);
        logic  fire, stall, prev_last;
        beat_t prev_d;
        @(negedge clk);
        in_valid  = v;
        in_sop    = sop;
        data_in   = d;
        out_ready = ordy;
        acc       = v && (frames_q.size() < 2);
        fire      = (frames_q.size() > 0) && ordy;
        stall     = (out_valid0 === 1'b1) && !ordy;
        prev_d    = data_out0;
        prev_last = out_last0;
        if (out_valid0 === 1'b1 && ordy) begin
            dut_fires++;
            if (out_last0 === 1'b1) dut_lasts++;
        end
        @(posedge clk);
        #1;
        if (fire) begin
            if (m_beat == 3) begin
                void'(frames_q.pop_front());
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (acc) begin
            if (sop) begin
                part[0] = d;
                part_n  = 1;
            end else begin
                part[part_n] = d;
                part_n++;
                if (part_n == 16) begin
                    frame_t f;
                    for (int j = 0; j < 16; j++) f[j*DW +: DW] = part[j];
                    frames_q.push_back(f);
                    part_n = 0;
                end
            end
        end
        if (stall) begin
            check("hold.data", data_out0, prev_d);
            check("hold.last", beat_t'(out_last0), beat_t'(prev_last));
        end
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cycle(1'b0, 1'b0, '0, ordy, acc);
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic ordy);
        logic acc;
        for (int i = 0; i < 16; i++) cycle(1'b1, i == 0, base + DW'(i), ordy, acc);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && frames_q.size() > 0; i++) idle(1'b1);
        check("drained", beat_t'(frames_q.size()), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check("rst.in_ready", beat_t'(in_ready0), beat_t'(1'b1));
        check("rst.out_valid", beat_t'(out_valid0), '0);
        check("rst.out_valid_br", beat_t'(out_valid1), '0);
        check("rst.out_last", beat_t'(out_last0), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        int   sent;
        int   fires0, lasts0;

        checks   = 0;
        failures = 0;
        dut_fires = 0;
        dut_lasts = 0;
        model_clear();

        for (int i = 0; i < 16; i++) in_tbl[i] = '{din: DW'(i), sop: (i == 0), exp_in_ready: 1'b1};
        beat_tbl[0] = '{nat: 16'h3210, rev: 16'hC480, last: 1'b0};
        beat_tbl[1] = '{nat: 16'h7654, rev: 16'hE6A2, last: 1'b0};
        beat_tbl[2] = '{nat: 16'hBA98, rev: 16'hD591, last: 1'b0};
        beat_tbl[3] = '{nat: 16'hFEDC, rev: 16'hF7B3, last: 1'b1};

        // Reset state and samples 0..F in natural and bit-reversed order.
        cur_tag = "t1";
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, in_tbl[i].sop, in_tbl[i].din, 1'b1, acc);
            check("tbl.in_ready", beat_t'(in_ready0), beat_t'(in_tbl[i].exp_in_ready));
        end
        for (int k = 0; k < 4; k++) begin
            check("tbl.valid", beat_t'(out_valid0), beat_t'(1'b1));
            check("tbl.nat", data_out0, widen(beat_tbl[k].nat));
            check("tbl.rev", data_out1, widen(beat_tbl[k].rev));
            check("tbl.last", beat_t'(out_last0), beat_t'(beat_tbl[k].last));
            idle(1'b1);
        end
        check("tbl.end_valid", beat_t'(out_valid0), '0);

        // Three back-to-back frames against a stalled consumer.
        cur_tag = "t3";
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(1'b1, 1'b0, DW'(32'h200 + sent), 1'b0, acc);
            if (acc) sent++;
        end
        check("accepted_before_stall", beat_t'(sent), beat_t'(32));
        check("in_ready_low", beat_t'(in_ready0), '0);
        fires0 = dut_fires;
        for (int c = 0; c < 200 && (sent < 48 || frames_q.size() > 0); c++) begin
            cycle(sent < 48, 1'b0, DW'(32'h200 + sent), 1'b1, acc);
            if (acc) sent++;
        end
        check("sent_all", beat_t'(sent), beat_t'(48));
        check("beats", beat_t'(dut_fires - fires0), beat_t'(12));
        check("drained", beat_t'(frames_q.size()), '0);

        // Random input gaps and 50% consumer back-pressure over four frames.
        cur_tag = "t4";
        sent   = 0;
        fires0 = dut_fires;
        lasts0 = dut_lasts;
        for (int c = 0; c < 2000 && (sent < 64 || frames_q.size() > 0); c++) begin
            logic v;
            v = (sent < 64) && ($urandom_range(0, 1) == 1);
            cycle(v, 1'b0, DW'({$urandom, $urandom}), $urandom_range(0, 1) == 1, acc);
            if (acc) sent++;
        end
        check("sent_all", beat_t'(sent), beat_t'(64));
        check("beats", beat_t'(dut_fires - fires0), beat_t'(16));
        check("last_pulses", beat_t'(dut_lasts - lasts0), beat_t'(4));

        // Mid-frame in_sop discards the 7 stale samples.
        cur_tag = "t5";
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DW'(32'h50 + i), 1'b1, acc);
        send_frame(DW'(32'h100), 1'b1);
        check("sop.valid", beat_t'(out_valid0), beat_t'(1'b1));
        check("sop.lane0", beat_t'(data_out0[DW-1:0]), beat_t'(32'h100));
        check("sop.lane0_br", beat_t'(data_out1[DW-1:0]), beat_t'(32'h100));
        drain(10);

        // Reset while beat 2 is on the bus, then a clean frame.
        cur_tag = "t6";
        send_frame(DW'(32'h300), 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("mid_drain_beat2", beat_t'(data_out0[DW-1:0]), beat_t'(32'h308));
        do_reset();
        send_frame(DW'(32'h400), 1'b1);
        check("post_rst.lane0", beat_t'(data_out0[DW-1:0]), beat_t'(32'h400));
        check("post_rst.last", beat_t'(out_last0), '0);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
